cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter W, default 4, meaning the operand width in bits.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ, meaning the per-requester compare request, level-sensitive.
REQ-006 The block SHALL have port a_in, input, NREQ*W, meaning the packed A operands, with requester i at bits [i*W +: W].
REQ-007 The block SHALL have port b_in, input, NREQ*W, meaning the packed B operands, with the same packing as a_in.
REQ-008 The block SHALL have port gnt, output, NREQ, meaning the one-hot grant, combinational, asserted only in IDLE.
REQ-009 The block SHALL have port busy, output, 1, meaning high whenever the state is not IDLE.
REQ-010 The block SHALL have port resp_valid, output, 1, meaning a result is available.
REQ-011 The block SHALL have port resp_ready, input, 1, meaning the consumer accepts the result.
REQ-012 The block SHALL have port resp_id, output, clog2(NREQ), meaning the index of the requester that owns the result.
REQ-013 The block SHALL have ports resp_gt, resp_lt and resp_eq, each output, 1, meaning A>B, A<B and A==B (unsigned), one-hot while resp_valid is high.

Function
REQ-014 The FSM SHALL have the states IDLE, CMP and RESP.
REQ-015 In IDLE with req!=0, the block SHALL assert gnt for exactly one winner and, on the clock edge, capture that winner's a, b and index into registers, then go to CMP.
REQ-016 In IDLE with req==0, gnt SHALL be 0 and the state SHALL stay IDLE.
REQ-017 In CMP, the shared comparator core SHALL evaluate the captured operands, and the registered gt/lt/eq SHALL be loaded on the clock edge, with the state going to RESP.
REQ-018 In RESP, resp_valid SHALL be 1 and resp_* SHALL be held stable until resp_valid && resp_ready, after which the state SHALL go to IDLE.
REQ-019 Latency SHALL be fixed: a grant in cycle N gives resp_valid in cycle N+2; the minimum issue interval SHALL be 3 cycles.
REQ-020 Arbitration SHALL be round-robin: search starts at ptr, the first set req bit at or after ptr (wrapping) wins, and on grant ptr SHALL become (winner+1) mod NREQ.
REQ-021 The captured operands SHALL be immune to a_in, b_in or req changing after the grant edge.
REQ-022 The block SHALL NOT grant while in CMP or RESP, and requests held during those states SHALL be served once back in IDLE.
REQ-023 When resp_ready is already high on entry to RESP, resp_valid SHALL last exactly one cycle.
REQ-024 Equal operands SHALL give resp_eq=1 and gt=lt=0, including the values 0 and 2^W-1.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously force state=IDLE, ptr=0, resp_valid=0, resp_gt=resp_lt=resp_eq=0 and resp_id=0; gnt and busy SHALL then be derived outputs.
REQ-026 Reset asserted in CMP or RESP SHALL abandon the operation, and the result SHALL NOT be presented after reset release.
REQ-027 The first grant after reset release SHALL follow the ptr=0 search order.

Configuration
REQ-028 With macro CMP_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, with the lowest index winning and ptr neither used nor updated.
REQ-029 With CMP_ARB_FIXED_PRIO_EN undefined, the round-robin behaviour of REQ-020 SHALL apply.

Structure
REQ-030 The shared package cmp_pkg SHALL hold the FSM state enum (IDLE, CMP, RESP), the compare-result struct {gt, lt, eq} and the default W constant.
REQ-031 The comparator SHALL be a separate sub-module, mag_cmp (combinational, W-bit unsigned, gt/lt/eq outputs), instantiated exactly once.

Verification
REQ-032 The bench SHALL cover: single requester, req=0001, a0=9, b0=3 -> gnt=0001 at cycle 0, resp_valid at cycle 2 with id=0 and gt=1.
REQ-033 The bench SHALL cover: all requesters, req=1111 held with resp_ready=1 -> grants 0,1,2,3,0 in sequence, one every 3 cycles.
REQ-034 The bench SHALL cover: backpressure, resp_ready=0 for 5 cycles with a=4, b=4 -> resp_valid stays high with eq=1 held, no gnt until accept, then IDLE.
REQ-035 The bench SHALL cover: operand change, a2=0 at grant, then a2=15 in CMP with b2=1 -> resp_lt=1 and id=2.
REQ-036 The bench SHALL cover: reset mid-op, rst_n low during CMP -> resp_valid=0 immediately, and after release with req=1000 the grant goes to 3 with ptr restarting from 0.
REQ-037 The bench SHALL cover: with CMP_ARB_FIXED_PRIO_EN, req=0110 held -> every grant goes to requester 1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter: FSM states, compare result
// record and the default operand width.
package cmp_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between requesters+consumer (master) and the
// compare arbiter (slave). Operands are packed, requester i at [i*W +: W].
interface cmp_arbiter_if
  import cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic              resp_gt;
  logic              resp_lt;
  logic              resp_eq;

  modport master (
    output req, a_in, b_in, resp_ready,
    input  gnt, busy, resp_valid, resp_id, resp_gt, resp_lt, resp_eq
  );

  modport slave (
    input  req, a_in, b_in, resp_ready,
    output gnt, busy, resp_valid, resp_id, resp_gt, resp_lt, resp_eq
  );
endinterface

// File: rtl/mag_cmp.sv
// Combinational W-bit unsigned magnitude comparator.
module mag_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

// File: rtl/cmp_arbiter.sv
// Compare arbiter: picks one requester, captures its operands, runs them
// through a single shared comparator and holds the result until accepted.
// Round-robin by default; define CMP_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, pointer frozen at 0).
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  cmp_arbiter_if.slave   bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  cmp_res_t        res_q, res_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  win_next;
  logic [NREQ-1:0] gnt_v;
  cmp_res_t        cmp_out;

  // Winner search: first set request at or after the start index, wrapping.
  always_comb begin
    int base;
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
`ifdef CMP_ARB_FIXED_PRIO_EN
    base  = 0;
`else
    base  = int'(ptr_q);
`endif
    for (int off = 0; off < NREQ; off++) begin
      idx = base + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign win_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  // One-hot grant, only offered while idle.
  always_comb begin
    gnt_v = '0;
    if (state_q == IDLE && found) gnt_v[win] = 1'b1;
  end

  mag_cmp #(.W(W)) u_mag_cmp (
    .a  (a_q),
    .b  (b_q),
    .gt (cmp_out.gt),
    .lt (cmp_out.lt),
    .eq (cmp_out.eq)
  );

  // Next-state and datapath-load decisions for the IDLE -> CMP -> RESP loop.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    res_d        = res_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = bus.a_in[int'(win)*W +: W];
          b_d     = bus.b_in[int'(win)*W +: W];
          id_d    = win;
`ifndef CMP_ARB_FIXED_PRIO_EN
          ptr_d   = win_next;
`endif
          state_d = CMP;
        end
      end
      CMP: begin
        res_d        = cmp_out;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      res_q        <= res_d;
    end
  end

  assign bus.gnt        = gnt_v;
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_gt    = res_q.gt;
  assign bus.resp_lt    = res_q.lt;
  assign bus.resp_eq    = res_q.eq;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_cmp_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Expected {gt,lt,eq} for a_i = i, b_i = 2 (hand-computed).
  logic [2:0] rr_res [4] = '{3'b010, 3'b010, 3'b001, 3'b100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] res3();
    return 32'({bus.resp_gt, bus.resp_lt, bus.resp_eq});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    sample();
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_valid", 32'(bus.resp_valid), 32'(0));
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_id", 32'(bus.resp_id), 32'(0));
    chk("rst_res", res3(), 32'(0));
    step();
    rst_n = 1'b1;

    // Single requester: 9 vs 3
    bus.req = 4'b0001;
    set_op(0, 4'd9, 4'd3);
    sample();
    $display("txn single: gnt=%b", bus.gnt);
    chk("single_gnt", 32'(bus.gnt), 32'(4'b0001));
    chk("single_busy0", 32'(bus.busy), 32'(0));
    step();
    bus.req = '0;
    sample();
    chk("single_cmp_busy", 32'(bus.busy), 32'(1));
    chk("single_cmp_valid", 32'(bus.resp_valid), 32'(0));
    chk("single_cmp_gnt", 32'(bus.gnt), 32'(0));
    step();
    sample();
    chk("single_valid", 32'(bus.resp_valid), 32'(1));
    chk("single_id", 32'(bus.resp_id), 32'(0));
    chk("single_res", res3(), 32'(3'b100));
    step();
    sample();
    chk("single_idle_valid", 32'(bus.resp_valid), 32'(0));
    chk("single_idle_busy", 32'(bus.busy), 32'(0));

    // All requesters held, consumer always ready
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i), 4'd2);
    bus.req = 4'b1111;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 4;
`endif
      sample();
      $display("txn rr %0d: gnt=%b", k, bus.gnt);
      chk("rr_gnt", 32'(bus.gnt), 32'(1) << e);
      step();
      sample();
      chk("rr_cmp_gnt", 32'(bus.gnt), 32'(0));
      step();
      sample();
      chk("rr_valid", 32'(bus.resp_valid), 32'(1));
      chk("rr_id", 32'(bus.resp_id), 32'(e));
      chk("rr_res", res3(), 32'(rr_res[e]));
      chk("rr_resp_gnt", 32'(bus.gnt), 32'(0));
      step();
    end

    // Backpressure: equal operands, consumer stalls 5 cycles
    do_reset();
    bus.req = 4'b0001;
    set_op(0, 4'd4, 4'd4);
    bus.resp_ready = 1'b0;
    sample();
    $display("txn bp: gnt=%b", bus.gnt);
    chk("bp_gnt", 32'(bus.gnt), 32'(4'b0001));
    step();
    sample();
    chk("bp_cmp_busy", 32'(bus.busy), 32'(1));
    step();
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'(1));
      chk("bp_hold_res", res3(), 32'(3'b001));
      chk("bp_hold_gnt", 32'(bus.gnt), 32'(0));
      step();
    end
    bus.resp_ready = 1'b1;
    bus.req = '0;
    sample();
    chk("bp_accept_valid", 32'(bus.resp_valid), 32'(1));
    chk("bp_accept_res", res3(), 32'(3'b001));
    step();
    sample();
    chk("bp_after_busy", 32'(bus.busy), 32'(0));
    chk("bp_after_valid", 32'(bus.resp_valid), 32'(0));

    // Operands change after the grant edge
    do_reset();
    bus.req = 4'b0100;
    set_op(2, 4'd0, 4'd1);
    sample();
    $display("txn opchg: gnt=%b", bus.gnt);
    chk("opchg_gnt", 32'(bus.gnt), 32'(4'b0100));
    step();
    set_op(2, 4'd15, 4'd1);
    bus.req = '0;
    step();
    sample();
    chk("opchg_valid", 32'(bus.resp_valid), 32'(1));
    chk("opchg_id", 32'(bus.resp_id), 32'(2));
    chk("opchg_res", res3(), 32'(3'b010));
    step();

    // Equal extremes 15 == 15
    bus.req = 4'b0010;
    set_op(1, 4'd15, 4'd15);
    step();
    bus.req = '0;
    step();
    sample();
    $display("txn eqmax: id=%0d", bus.resp_id);
    chk("eqmax_res", res3(), 32'(3'b001));
    step();

    // Reset during CMP, then request 3 only
    do_reset();
    bus.req = 4'b0100;
    set_op(2, 4'd5, 4'd5);
    step();
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    chk("rstcmp_busy", 32'(bus.busy), 32'(0));
    chk("rstcmp_valid", 32'(bus.resp_valid), 32'(0));
    step();
    rst_n = 1'b1;
    sample();
    chk("rstcmp_nores", 32'(bus.resp_valid), 32'(0));
    step();
    sample();
    chk("rstcmp_nores2", 32'(bus.resp_valid), 32'(0));
    step();
    bus.req = 4'b1000;
    sample();
    $display("txn rst_cmp: gnt=%b", bus.gnt);
    chk("rstcmp_gnt3", 32'(bus.gnt), 32'(4'b1000));
    step();
    bus.req = '0;
    step();
    step();

    // Reset during RESP; pointer must restart from 0
    bus.req = 4'b0100;
    bus.resp_ready = 1'b0;
    step();
    bus.req = '0;
    step();
    sample();
    chk("rstresp_pre_valid", 32'(bus.resp_valid), 32'(1));
    step();
    rst_n = 1'b0;
    #1;
    chk("rstresp_valid", 32'(bus.resp_valid), 32'(0));
    step();
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req = 4'b1010;
    sample();
    $display("txn rst_resp: gnt=%b", bus.gnt);
    chk("rstresp_gnt_ptr0", 32'(bus.gnt), 32'(4'b0010));
    step();
    bus.req = '0;
    step();
    step();

    // req=0110 held: fixed priority always 1, round robin alternates
    do_reset();
    bus.req = 4'b0110;
    for (int k = 0; k < 3; k++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
      e = 1;
`else
      e = (k % 2 == 0) ? 1 : 2;
`endif
      sample();
      $display("txn prio %0d: gnt=%b", k, bus.gnt);
      chk("prio_gnt", 32'(bus.gnt), 32'(1) << e);
      step();
      step();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
